// File: rtl/input_encoder.sv
// Debounces 12 switches and 4 buttons and sends one ASCII code per debounced level
// change to a UART TX byte interface, so a remote toggle decoder can mirror the inputs.
//
// state | meaning
// IDLE  | no byte offered; grants the lowest pending input, if any
// SEND  | byte held on tx_data with tx_valid high until tx_ready accepts it
module input_encoder #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CODE_BASE       = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] switches_in,
    input  logic [3:0]  buttons_in,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [11:0] switches_db,
    output logic [3:0]  buttons_db,
    output logic [15:0] pending
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [7:0]    CODE_BASE_B = 8'(CODE_BASE);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "input_encoder: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $fatal(1, "input_encoder: DEBOUNCE_CYCLES must be at least 1");
    end
    if (CODE_BASE + 15 > 255) begin : g_bad_code_base
        $fatal(1, "input_encoder: CODE_BASE + 15 does not fit in 8 bits");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [SYNC_STAGES-1:0][15:0]  sync_q, sync_d;
    logic [15:0][CW-1:0]           cnt_q, cnt_d;
    logic [15:0]                   db_q, db_d;
    logic [15:0]                   db_dly_q, db_dly_d;
    logic [15:0]                   pending_q, pending_d;
    logic                          tx_valid_q, tx_valid_d;
    logic [7:0]                    tx_data_q, tx_data_d;

    logic [15:0] in_raw;
    logic [15:0] synced;
    logic [15:0] chg;
    logic [15:0] grant;
    logic [3:0]  grant_idx;

    assign in_raw = {buttons_in, switches_in};
    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = in_raw;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // Counter only runs while the synced level disagrees with the accepted level.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        for (int i = 0; i < 16; i++) begin
            if (synced[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i]  = synced[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    assign db_dly_d = db_q;
    assign chg      = db_q ^ db_dly_q;

    // Scanning downward leaves the lowest set index as the winner.
    always_comb begin
        grant_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant_idx = 4'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        grant      = '0;
        case (state_q)
            IDLE: begin
                tx_valid_d = 1'b0;
                if (pending_q != '0) begin
                    grant      = 16'(1) << grant_idx;
                    tx_data_d  = CODE_BASE_B + {4'b0000, grant_idx};
                    tx_valid_d = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // A change landing on a bit being granted re-arms it rather than cancelling.
    assign pending_d = (pending_q & ~grant) ^ chg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            cnt_q      <= '0;
            db_q       <= '0;
            db_dly_q   <= '0;
            pending_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            db_q       <= db_d;
            db_dly_q   <= db_dly_d;
            pending_q  <= pending_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign switches_db = db_q[11:0];
    assign buttons_db  = db_q[15:12];
    assign pending     = pending_q;

endmodule
